l2_word_lookup: RTL and testbench
=================================

# l2_word_lookup

Parametrised, word-granular tag lookup stage for the Spandex L2. It compares a request tag against all ways of a set read from the tag/state arrays and returns a registered response:
- hit way and empty way
- per-word shared, owned and valid masks
- a round-robin eviction candidate

It sits between the set-read stage and the L2 controller FSM. A valid/ready handshake on both sides lets the controller stall it.

## Interface
Parameters:
- WAYS, 8, ways per set; power of two, ≥2
- TAG_BITS, 15, tag width
- WORDS, 4, words per line
- WAY_BITS, $clog2(WAYS), way index width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_mode  in  1  0 = LOOKUP (CPU request), 1 = LOOKUP_FWD (forward/probe)
- req_tag  in  TAG_BITS  tag to match
- req_tags  in  WAYS*TAG_BITS  tag of way i at [i*TAG_BITS +: TAG_BITS]
- req_states  in  WAYS*WORDS*2  state of way i, word w at [(i*WORDS+w)*2 +: 2]; encoding 00 I, 01 V, 10 S, 11 R
- evict_adv  in  1  pulse: controller consumed the eviction candidate; advance the pointer
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_tag_hit  out  1  a matching, non-invalid way exists
- rsp_way_hit  out  WAY_BITS  hit way
- rsp_empty_found  out  1  a fully invalid way exists
- rsp_empty_way  out  WAY_BITS  empty way
- rsp_evict_way  out  WAY_BITS  round-robin eviction candidate
- rsp_mask_valid / rsp_mask_shared / rsp_mask_owned  out  WORDS each  per-word masks of the hit way
- err_multi_hit  out  1  sticky: more than one way matched

## Operation
- **Way validity:** way i is valid iff any of its words ≠ I. It is empty iff all of its words = I.
- **Tag hit:** req_tags[i] == req_tag and way i is valid. When several ways hit, the lowest index wins.
- **Empty way:** the lowest-index empty way.
- **Masks, hit way only:**
  - valid[w] = state ≠ I
  - shared[w] = state ∈ {S, R}
  - owned[w] = state == R
  - All masks are 0 on a miss.
- **LOOKUP mode:** computes hit, empty and masks.
- **LOOKUP_FWD mode:** computes hit and masks. rsp_empty_found = 0 and rsp_empty_way = 0.
- **Eviction pointer:**
  - Internal WAY_BITS counter; reset value 0.
  - +1 on each evict_adv, wrapping from WAYS-1 to 0.
  - Sampled into rsp_evict_way at request accept.
  - When evict_adv and accept occur in the same cycle, the pre-increment value is sampled.
- **Handshake:** req_ready = !rsp_valid || rsp_ready, combinational, one-deep. While rsp_valid && !rsp_ready, all rsp_* outputs hold stable.
- **Reset (asynchronous):**
  - All outputs 0 and the pointer 0.
  - rsp_valid drops immediately, including mid-stall. The pending response is discarded.
  - req_ready = 1 after reset.

## Timing
- Latency: exactly 1 cycle from accept to rsp_valid.
- Throughput: 1 lookup per cycle while rsp_ready = 1.
- Simultaneous events:
  - In the cycle rsp_valid && rsp_ready with a new accept, the new response loads at the next edge and rsp_valid stays 1.
  - With no new accept, rsp_valid falls to 0.
- Input sampling: req_tags, req_states, req_tag and req_mode are sampled only at accept and may change freely otherwise.
- err_multi_hit: set at the accept edge of a multi-hit lookup (either mode). It is cleared only by rst.

## Configuration
- **L2_LOOKUP_MULTI_HIT_CHK_EN defined:** the multi-way match detector and the sticky err_multi_hit register are compiled in.
- **Not defined:** err_multi_hit is tied 0 and the detector logic is absent. Hit selection (lowest index) is identical either way.

## Test plan
- **Basic hit:** WAYS=8. Tag 0x12 in way 5 with words {R,S,V,I}, other ways empty, LOOKUP, rsp_ready=1. Next cycle: rsp_valid=1, hit=1, way_hit=5, empty_found=1, empty_way=0, mask_valid=0111, shared=0011, owned=0001 (bit w = word w).
- **Multi-hit:** tag matches in ways 2 and 6. Response way_hit=2. err_multi_hit=1 and it stays 1 through 10 further clean lookups (with the macro defined). Without the macro it stays 0.
- **FWD mode:** all ways valid, tag miss. FWD lookup → hit=0, all masks 0, empty_found=0, rsp_evict_way = current pointer.
- **Stall:** rsp_ready=0 for 3 cycles after a response. req_ready=0 and the outputs stay constant. Raise rsp_ready with req_valid=1 → back-to-back responses with no bubble.
- **Pointer wrap and race:**
  - 8 evict_adv pulses bring the pointer back to 0.
  - evict_adv coincident with accept at pointer 7: rsp_evict_way=7, next accept sees 0.
- **Reset mid-stall:** assert rst while rsp_valid=1, rsp_ready=0. rsp_valid=0 asynchronously, all outputs 0. After deassert, req_ready=1 and the first response has rsp_evict_way=0.

Source files
------------

// File: rtl/l2_word_lookup.sv
// l2_word_lookup: word-granular tag lookup stage for the Spandex L2.
// Compares a request tag against every way of a set, and produces a registered
// response. The response carries the hit way, the first empty way, the per-word
// valid/shared/owned masks of the hit way, and a round-robin eviction candidate.
// Sits between the set-read stage and the L2 controller FSM, with valid/ready on
// both sides and a one-deep response register.
// Optional feature macro: L2_LOOKUP_MULTI_HIT_CHK_EN compiles in the multi-way
// match detector and the sticky err_multi_hit flag; otherwise err_multi_hit is 0.
module l2_word_lookup #(
    parameter int WAYS     = 8,
    parameter int TAG_BITS = 15,
    parameter int WORDS    = 4,
    parameter int WAY_BITS = $clog2(WAYS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_mode,
    input  logic [TAG_BITS-1:0]       req_tag,
    input  logic [WAYS*TAG_BITS-1:0]  req_tags,
    input  logic [WAYS*WORDS*2-1:0]   req_states,
    input  logic                      evict_adv,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_tag_hit,
    output logic [WAY_BITS-1:0]       rsp_way_hit,
    output logic                      rsp_empty_found,
    output logic [WAY_BITS-1:0]       rsp_empty_way,
    output logic [WAY_BITS-1:0]       rsp_evict_way,
    output logic [WORDS-1:0]          rsp_mask_valid,
    output logic [WORDS-1:0]          rsp_mask_shared,
    output logic [WORDS-1:0]          rsp_mask_owned,
    output logic                      err_multi_hit
);

    // Word state encoding: 00 I, 01 V, 10 S, 11 R
    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_R = 2'b11;

    // A word holds data whenever it is not Invalid
    function automatic logic st_is_valid(input logic [1:0] st);
        return (st != ST_I);
    endfunction

    // S and R both count as shared copies
    function automatic logic st_is_shared(input logic [1:0] st);
        return st[1];
    endfunction

    // Only R grants ownership of the word
    function automatic logic st_is_owned(input logic [1:0] st);
        return (st == ST_R);
    endfunction

    logic                      accept_s;
    logic [WAYS-1:0]           way_valid_s;
    logic [WAYS-1:0]           hit_vec_s;
    logic                      tag_hit_s;
    logic [WAY_BITS-1:0]       hit_way_s;
    logic                      empty_found_s;
    logic [WAY_BITS-1:0]       empty_way_s;
    logic [WORDS*2-1:0]        hit_states_s;
    logic [WORDS-1:0]          mask_valid_s;
    logic [WORDS-1:0]          mask_shared_s;
    logic [WORDS-1:0]          mask_owned_s;

    logic [WAY_BITS-1:0]       evict_ptr_r;
    logic                      rsp_valid_r;
    logic                      rsp_tag_hit_r;
    logic [WAY_BITS-1:0]       rsp_way_hit_r;
    logic                      rsp_empty_found_r;
    logic [WAY_BITS-1:0]       rsp_empty_way_r;
    logic [WAY_BITS-1:0]       rsp_evict_way_r;
    logic [WORDS-1:0]          rsp_mask_valid_r;
    logic [WORDS-1:0]          rsp_mask_shared_r;
    logic [WORDS-1:0]          rsp_mask_owned_r;

    // One-deep pipe: a new request fits when the slot is empty or draining now
    assign req_ready = !rsp_valid_r || rsp_ready;
    assign accept_s  = req_valid && req_ready;

    // Per-way validity (any word not I) and tag match of valid ways
    always_comb begin
        way_valid_s = {WAYS{1'b0}};
        hit_vec_s   = {WAYS{1'b0}};
        for (int i = 0; i < WAYS; i++) begin
            way_valid_s[i] = |req_states[i*WORDS*2 +: WORDS*2];
            hit_vec_s[i]   = way_valid_s[i] &&
                             (req_tags[i*TAG_BITS +: TAG_BITS] == req_tag);
        end
    end

    // Lowest-index hit way and lowest-index empty way; scanning downward lets the lowest index win
    always_comb begin
        tag_hit_s     = |hit_vec_s;
        empty_found_s = ~&way_valid_s;
        hit_way_s     = {WAY_BITS{1'b0}};
        empty_way_s   = {WAY_BITS{1'b0}};
        for (int i = WAYS - 1; i >= 0; i--) begin
            hit_way_s   = hit_vec_s[i]    ? WAY_BITS'(i) : hit_way_s;
            empty_way_s = !way_valid_s[i] ? WAY_BITS'(i) : empty_way_s;
        end
    end

    // Word states of the selected hit way, then per-word masks gated by the hit
    always_comb begin
        hit_states_s  = {(WORDS*2){1'b0}};
        mask_valid_s  = {WORDS{1'b0}};
        mask_shared_s = {WORDS{1'b0}};
        mask_owned_s  = {WORDS{1'b0}};
        for (int i = 0; i < WAYS; i++) begin
            hit_states_s = (hit_way_s == WAY_BITS'(i)) ?
                           req_states[i*WORDS*2 +: WORDS*2] : hit_states_s;
        end
        for (int w = 0; w < WORDS; w++) begin
            mask_valid_s[w]  = tag_hit_s && st_is_valid(hit_states_s[w*2 +: 2]);
            mask_shared_s[w] = tag_hit_s && st_is_shared(hit_states_s[w*2 +: 2]);
            mask_owned_s[w]  = tag_hit_s && st_is_owned(hit_states_s[w*2 +: 2]);
        end
    end

    // Round-robin eviction pointer; the power-of-two way count gives a natural wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evict_ptr_r <= {WAY_BITS{1'b0}};
        end else if (evict_adv) begin
            evict_ptr_r <= evict_ptr_r + {{(WAY_BITS-1){1'b0}}, 1'b1};
        end
    end

    // Response valid: set on accept, cleared when consumed without a replacement
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_r <= 1'b0;
        end else if (accept_s) begin
            rsp_valid_r <= 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

    // Response payload loads only on accept, so it holds steady through a stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_tag_hit_r     <= 1'b0;
            rsp_way_hit_r     <= {WAY_BITS{1'b0}};
            rsp_empty_found_r <= 1'b0;
            rsp_empty_way_r   <= {WAY_BITS{1'b0}};
            rsp_evict_way_r   <= {WAY_BITS{1'b0}};
            rsp_mask_valid_r  <= {WORDS{1'b0}};
            rsp_mask_shared_r <= {WORDS{1'b0}};
            rsp_mask_owned_r  <= {WORDS{1'b0}};
        end else if (accept_s) begin
            rsp_tag_hit_r     <= tag_hit_s;
            rsp_way_hit_r     <= hit_way_s;
            // Forward probes never allocate, so no empty way is reported
            rsp_empty_found_r <= req_mode ? 1'b0 : empty_found_s;
            rsp_empty_way_r   <= req_mode ? {WAY_BITS{1'b0}} : empty_way_s;
            // Pre-increment pointer value, even when evict_adv fires this cycle
            rsp_evict_way_r   <= evict_ptr_r;
            rsp_mask_valid_r  <= mask_valid_s;
            rsp_mask_shared_r <= mask_shared_s;
            rsp_mask_owned_r  <= mask_owned_s;
        end
    end

`ifdef L2_LOOKUP_MULTI_HIT_CHK_EN
    logic multi_hit_s;
    logic err_multi_hit_r;

    // True when at least two bits of the vector are set
    function automatic logic more_than_one(input logic [WAYS-1:0] vec);
        return |(vec & (vec - {{(WAYS-1){1'b0}}, 1'b1}));
    endfunction

    assign multi_hit_s = more_than_one(hit_vec_s);

    // Sticky multi-hit flag, armed at the accept edge and cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_multi_hit_r <= 1'b0;
        end else if (accept_s && multi_hit_s) begin
            err_multi_hit_r <= 1'b1;
        end
    end

    assign err_multi_hit = err_multi_hit_r;
`else
    assign err_multi_hit = 1'b0;
`endif

    assign rsp_valid       = rsp_valid_r;
    assign rsp_tag_hit     = rsp_tag_hit_r;
    assign rsp_way_hit     = rsp_way_hit_r;
    assign rsp_empty_found = rsp_empty_found_r;
    assign rsp_empty_way   = rsp_empty_way_r;
    assign rsp_evict_way   = rsp_evict_way_r;
    assign rsp_mask_valid  = rsp_mask_valid_r;
    assign rsp_mask_shared = rsp_mask_shared_r;
    assign rsp_mask_owned  = rsp_mask_owned_r;

endmodule

// File: tb/tb_l2_word_lookup.sv
// Self-checking bench for l2_word_lookup (WAYS=8, TAG_BITS=15, WORDS=4).
// A reference model computes each expected response when a request is accepted
// and queues it; the queue head is compared against the DUT outputs every cycle
// while a response is pending.
module tb_l2_word_lookup;

    localparam logic [1:0] I = 2'b00;
    localparam logic [1:0] V = 2'b01;
    localparam logic [1:0] S = 2'b10;
    localparam logic [1:0] R = 2'b11;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_mode;
    logic [14:0]   req_tag;
    logic [119:0]  req_tags;
    logic [63:0]   req_states;
    logic          evict_adv;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_tag_hit;
    logic [2:0]    rsp_way_hit;
    logic          rsp_empty_found;
    logic [2:0]    rsp_empty_way;
    logic [2:0]    rsp_evict_way;
    logic [3:0]    rsp_mask_valid;
    logic [3:0]    rsp_mask_shared;
    logic [3:0]    rsp_mask_owned;
    logic          err_multi_hit;

    typedef struct {
        logic       hit;
        logic [2:0] way;
        logic       ef;
        logic [2:0] ew;
        logic [2:0] ev;
        logic [3:0] mv;
        logic [3:0] ms;
        logic [3:0] mo;
        logic       multi;
    } exp_t;

    exp_t       q[$];
    logic [2:0] ptr_m;
    logic       err_m;
    int         checks;
    int         errors;

    l2_word_lookup #(.WAYS(8), .TAG_BITS(15), .WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_tag(req_tag), .req_tags(req_tags), .req_states(req_states),
        .evict_adv(evict_adv),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_tag_hit(rsp_tag_hit), .rsp_way_hit(rsp_way_hit),
        .rsp_empty_found(rsp_empty_found), .rsp_empty_way(rsp_empty_way),
        .rsp_evict_way(rsp_evict_way),
        .rsp_mask_valid(rsp_mask_valid), .rsp_mask_shared(rsp_mask_shared),
        .rsp_mask_owned(rsp_mask_owned),
        .err_multi_hit(err_multi_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_set();
        req_tags   = 120'd0;
        req_states = 64'd0;
    endtask

    task automatic set_way(input int i, input logic [14:0] t,
                           input logic [1:0] s0, input logic [1:0] s1,
                           input logic [1:0] s2, input logic [1:0] s3);
        req_tags[i*15 +: 15]        = t;
        req_states[(i*4+0)*2 +: 2]  = s0;
        req_states[(i*4+1)*2 +: 2]  = s1;
        req_states[(i*4+2)*2 +: 2]  = s2;
        req_states[(i*4+3)*2 +: 2]  = s3;
    endtask

    // Reference lookup over the currently driven request
    function automatic exp_t model();
        exp_t       e;
        bit         found;
        bit         efound;
        int         hits;
        logic [1:0] st;
        e = '{default: '0};
        found = 1'b0;
        efound = 1'b0;
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            bit any;
            any = 1'b0;
            for (int w = 0; w < 4; w++) begin
                if (req_states[(i*4+w)*2 +: 2] != I) any = 1'b1;
            end
            if (any && req_tags[i*15 +: 15] == req_tag) begin
                hits++;
                if (!found) begin found = 1'b1; e.way = 3'(i); end
            end
            if (!any && !efound) begin efound = 1'b1; e.ew = 3'(i); end
        end
        e.hit = found;
        if (req_mode) begin
            efound = 1'b0;
            e.ew = 3'd0;
        end
        e.ef = efound;
        if (found) begin
            for (int w = 0; w < 4; w++) begin
                st = req_states[(int'(e.way)*4+w)*2 +: 2];
                e.mv[w] = (st != I);
                e.ms[w] = (st == S) || (st == R);
                e.mo[w] = (st == R);
            end
        end
        e.ev = ptr_m;
        e.multi = (hits > 1);
        return e;
    endfunction

    // One clock: check at the falling edge, update the model, advance to posedge+1
    task automatic cycle();
        bit   acc;
        bit   cons;
        exp_t e;
        #4;
        chk("rsp_valid", rsp_valid, q.size() != 0);
        chk("req_ready", req_ready, (q.size() == 0) || rsp_ready);
        chk("err_multi_hit", err_multi_hit, err_m);
        if (q.size() != 0) begin
            chk("tag_hit", rsp_tag_hit, q[0].hit);
            chk("way_hit", rsp_way_hit, q[0].way);
            chk("empty_found", rsp_empty_found, q[0].ef);
            chk("empty_way", rsp_empty_way, q[0].ew);
            chk("evict_way", rsp_evict_way, q[0].ev);
            chk("mask_valid", rsp_mask_valid, q[0].mv);
            chk("mask_shared", rsp_mask_shared, q[0].ms);
            chk("mask_owned", rsp_mask_owned, q[0].mo);
        end
        acc  = req_valid && ((q.size() == 0) || rsp_ready);
        cons = (q.size() != 0) && rsp_ready;
        if (cons) void'(q.pop_front());
        if (acc) begin
            e = model();
            q.push_back(e);
`ifdef L2_LOOKUP_MULTI_HIT_CHK_EN
            if (e.multi) err_m = 1'b1;
`endif
        end
        if (evict_adv) ptr_m = ptr_m + 3'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ptr_m = 3'd0;
        err_m = 1'b0;
        rst = 1'b0;
        req_valid = 1'b0;
        req_mode = 1'b0;
        req_tag = 15'd0;
        evict_adv = 1'b0;
        rsp_ready = 1'b1;
        clear_set();

        // Reset state
        @(posedge clk);
        #1;
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_err", err_multi_hit, 1'b0);
        chk("reset_evict", rsp_evict_way, 3'd0);
        rst = 1'b1;
        cycle();

        // Basic hit: way 5 holds {R,S,V,I}, other ways empty
        clear_set();
        set_way(5, 15'h12, R, S, V, I);
        req_tag = 15'h12;
        req_valid = 1'b1;
        cycle();
        req_valid = 1'b0;
        chk("basic_way", rsp_way_hit, 3'd5);
        chk("basic_mv", rsp_mask_valid, 4'b0111);
        chk("basic_ms", rsp_mask_shared, 4'b0011);
        chk("basic_mo", rsp_mask_owned, 4'b0001);
        cycle();

        // Multi-hit in ways 2 and 6, then 10 clean lookups
        clear_set();
        set_way(2, 15'h33, V, I, I, I);
        set_way(6, 15'h33, S, S, I, I);
        req_tag = 15'h33;
        req_valid = 1'b1;
        cycle();
        req_valid = 1'b0;
        chk("multi_way", rsp_way_hit, 3'd2);
        req_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            clear_set();
            set_way(1, 15'(15'h40 + k), V, S, R, I);
            req_tag = 15'(15'h40 + k);
            cycle();
        end
        req_valid = 1'b0;
        cycle();
`ifdef L2_LOOKUP_MULTI_HIT_CHK_EN
        chk("multi_sticky", err_multi_hit, 1'b1);
`else
        chk("multi_absent", err_multi_hit, 1'b0);
`endif

        // FWD: all ways valid, tag miss; then FWD hit with an empty way present
        clear_set();
        for (int i = 0; i < 8; i++) set_way(i, 15'(15'h100 + i), V, I, I, I);
        req_tag = 15'h7;
        req_mode = 1'b1;
        req_valid = 1'b1;
        cycle();
        set_way(3, 15'h0, I, I, I, I);
        req_tag = 15'h104;
        cycle();
        req_valid = 1'b0;
        req_mode = 1'b0;
        cycle();

        // Pointer: 8 pulses wrap back to 0
        evict_adv = 1'b1;
        repeat (8) cycle();
        evict_adv = 1'b0;
        req_valid = 1'b1;
        cycle();
        req_valid = 1'b0;
        chk("wrap_evict", rsp_evict_way, 3'd0);
        // Advance to 7, then race evict_adv with accept
        evict_adv = 1'b1;
        repeat (7) cycle();
        req_valid = 1'b1;
        cycle();
        evict_adv = 1'b0;
        chk("race_evict", rsp_evict_way, 3'd7);
        cycle();
        req_valid = 1'b0;
        chk("after_race_evict", rsp_evict_way, 3'd0);
        cycle();

        // Stall for 3 cycles, then back-to-back responses
        clear_set();
        set_way(0, 15'h55, R, R, R, R);
        req_tag = 15'h55;
        req_valid = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        req_tag = 15'h56;
        repeat (3) cycle();
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_way(k, 15'(15'h60 + k), V, S, I, R);
            req_tag = 15'(15'h60 + k);
            cycle();
        end
        req_valid = 1'b0;
        cycle();

        // Pseudo-random lookups with random backpressure and pointer pulses
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 8; i++) req_tags[i*15 +: 15] = 15'($urandom_range(0, 3));
            req_states = {$urandom, $urandom};
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 3) == 0) req_states[i*8 +: 8] = 8'd0;
            end
            req_tag   = 15'($urandom_range(0, 3));
            req_mode  = 1'($urandom_range(0, 1));
            req_valid = 1'($urandom_range(0, 1));
            rsp_ready = 1'($urandom_range(0, 1));
            evict_adv = 1'($urandom_range(0, 1));
            cycle();
        end
        req_valid = 1'b0;
        req_mode = 1'b0;
        evict_adv = 1'b0;
        rsp_ready = 1'b1;
        cycle();

        // Reset mid-stall
        req_valid = 1'b1;
        evict_adv = 1'b1;
        cycle();
        req_valid = 1'b0;
        evict_adv = 1'b0;
        rsp_ready = 1'b0;
        cycle();
        #4;
        rst = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_tag_hit", rsp_tag_hit, 1'b0);
        chk("rst_way_hit", rsp_way_hit, 3'd0);
        chk("rst_empty_found", rsp_empty_found, 1'b0);
        chk("rst_empty_way", rsp_empty_way, 3'd0);
        chk("rst_evict_way", rsp_evict_way, 3'd0);
        chk("rst_mask_valid", rsp_mask_valid, 4'd0);
        chk("rst_mask_shared", rsp_mask_shared, 4'd0);
        chk("rst_mask_owned", rsp_mask_owned, 4'd0);
        chk("rst_err", err_multi_hit, 1'b0);
        q.delete();
        ptr_m = 3'd0;
        err_m = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        rsp_ready = 1'b1;
        chk("post_rst_req_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        cycle();
        req_valid = 1'b0;
        chk("post_rst_evict", rsp_evict_way, 3'd0);
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
